// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1-0-1 serial pattern detector.
package seq_det_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [2:0]  PATTERN = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_101  = 2'd3
  } state_e;

endpackage

// File: rtl/sequence_detector_101.sv
// Moore detector for the serial pattern 1-0-1; z pulses for one cycle per match.
// Define SEQ_DET_OVERLAP_EN to let the trailing 1 of a match start the next one.
module sequence_detector_101
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic z
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    z       = (state_q == S_101);
    unique case (state_q)
      S_IDLE:  state_d = x ? S_1   : S_IDLE;
      S_1:     state_d = x ? S_1   : S_10;
      S_10:    state_d = x ? S_101 : S_IDLE;
      S_101: begin
`ifdef SEQ_DET_OVERLAP_EN
        state_d = x ? S_1 : S_10;
`else
        state_d = x ? S_1 : S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequence_detector_101.sv
// Self-checking bench for sequence_detector_101: directed patterns plus random stream.
module tb_sequence_detector_101;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x = 1'b0;
  logic z;

  int checks = 0;
  int errors = 0;

  // reference model: recent bits since the last reset (or consumed match)
  logic [2:0]  hist = 3'b000;
  int unsigned hlen = 0;
  logic        exp_z = 1'b0;

  always #5 clk = ~clk;

  sequence_detector_101 dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .z     (z)
  );

  task automatic check_z(input string tag);
    checks++;
    assert (z === exp_z)
      else begin
        errors++;
        $error("FAIL %s: z=%0b expected %0b", tag, z, exp_z);
      end
  endtask

  task automatic step(input logic rst, input logic b, input string tag);
    @(negedge clk);
    reset = rst;
    x     = b;
    @(posedge clk);
    if (rst) begin
      hlen  = 0;
      exp_z = 1'b0;
    end else begin
      hist  = {hist[1:0], b};
      if (hlen < 3) hlen++;
      exp_z = (hlen >= 3) && (hist == PATTERN);
`ifndef SEQ_DET_OVERLAP_EN
      if (exp_z) hlen = 0;
`endif
    end
    #1;
    check_z(tag);
  endtask

  task automatic run_seq(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i], tag);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, "reset");
  endtask

  int pulses;

  initial begin
    // reset held two cycles while x toggles
    step(1'b1, 1'b1, "reset_hold0");
    step(1'b1, 1'b0, "reset_hold1");
    checks++;
    assert (dut.state_q === S_IDLE)
      else begin
        errors++;
        $error("FAIL reset_state: state=%0d expected %0d", dut.state_q, S_IDLE);
      end

    run_seq(16'b101, 3, "basic");
    step(1'b0, 1'b0, "basic_fall");

    do_reset();
    run_seq(16'b1011010010, 10, "long_seq");
    do_reset();
    run_seq(16'b10101, 5, "alt_seq");
    do_reset();
    run_seq(16'b101101, 6, "double_seq");
    do_reset();
    run_seq(16'b1101, 4, "prefix_11");
    do_reset();
    run_seq(16'b1001, 4, "prefix_00");

    // reset mid-pattern discards the partial 1,0
    do_reset();
    run_seq(16'b10, 2, "mid_pre");
    step(1'b1, 1'b1, "mid_reset");
    step(1'b0, 1'b1, "mid_after");
    run_seq(16'b01, 2, "mid_post");

    // independent pulse count on the canonical 1,0,1,0,1 stream
    do_reset();
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, (i % 2 == 0), "count_stream");
      if (z === 1'b1) pulses++;
    end
    checks++;
`ifdef SEQ_DET_OVERLAP_EN
    assert (pulses == 2)
      else begin
        errors++;
        $error("FAIL pulse_count: got %0d expected 2", pulses);
      end
`else
    assert (pulses == 1)
      else begin
        errors++;
        $error("FAIL pulse_count: got %0d expected 1", pulses);
      end
`endif

    // random stream with occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31) == 0), 1'($urandom_range(1)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
